// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared word/RAM-state types and arbiter state encoding.
package ram_arbiter_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
    typedef enum logic [2:0] {ARB_IDLE, ARB_IACC, ARB_DACC, ARB_IRESP, ARB_DRESP} arb_state_t;
    localparam int    TIMEOUT_DEF  = 64;
    localparam word_t ERR_DATA_DEF = 32'hBAD1BAD1;
endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request-unit handshake plus RAM port bundled for the arbiter.
interface ram_arbiter_if;
    import ram_arbiter_pkg::*;
    logic      imemREN;
    word_t     imemaddr;
    logic      dmemREN;
    logic      dmemWEN;
    word_t     dmemaddr;
    word_t     dmemstore;
    logic      ihit;
    logic      dhit;
    word_t     imemload;
    word_t     dmemload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      err;
    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
        output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, err
    );
    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload, ramstate,
        input  ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore, err
    );
endinterface

// File: rtl/ram_arbiter_access_timer.sv
// ram_arbiter_access_timer: clear/enable cycle counter flagging the last allowed access cycle.
module ram_arbiter_access_timer #(
    parameter int TIMEOUT = 64
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    logic [W-1:0] cnt_q;
    always_ff @(posedge CLK or posedge RST)
        if (RST) cnt_q <= '0;
        else if (clr_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + 1'b1;
    assign expired_o = cnt_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises instruction/data requests onto one RAM port with
// alternating priority, per-access timeout and one-cycle hit responses.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int    TIMEOUT  = TIMEOUT_DEF,
    parameter word_t ERR_DATA = ERR_DATA_DEF
) (
    input logic           CLK,
    input logic           RST,
    ram_arbiter_if.slave  bus
);
    arb_state_t state_q, state_d;
    logic  last_q, last_d, wen_q, wen_d, err_q, err_d;
    word_t addr_q, addr_d, store_q, store_d, iload_q, iload_d, dload_q, dload_d;
    logic  expired, in_acc, done, grant_d, d_acc;
    word_t rdata;

    assign in_acc  = state_q == ARB_IACC || state_q == ARB_DACC;
    assign d_acc   = state_q == ARB_DACC;
    assign done    = in_acc && (bus.ramstate == ACCESS || bus.ramstate == ERROR || expired);
    assign rdata   = bus.ramstate == ACCESS ? bus.ramload : ERR_DATA;
    // D wins unless I is also pending and D was granted last
    assign grant_d = (bus.dmemREN | bus.dmemWEN) & (~bus.imemREN | ~last_q);

    ram_arbiter_access_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .CLK       (CLK),
        .RST       (RST),
        .clr_i     (state_q == ARB_IDLE),
        .en_i      (in_acc),
        .expired_o (expired)
    );

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q <= ARB_IDLE;
            last_q  <= 1'b0;
            wen_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            store_q <= '0;
            iload_q <= '0;
            dload_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wen_q   <= wen_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            store_q <= store_d;
            iload_q <= iload_d;
            dload_q <= dload_d;
        end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wen_d   = wen_q;
        err_d   = err_q;
        addr_d  = addr_q;
        store_d = store_q;
        iload_d = iload_q;
        dload_d = dload_q;
        unique case (state_q)
            ARB_IDLE:
                if (grant_d) begin
                    state_d = ARB_DACC;
                    last_d  = 1'b1;
                    addr_d  = bus.dmemaddr;
                    store_d = bus.dmemstore;
                    wen_d   = bus.dmemWEN;
                    err_d   = err_q | (bus.dmemREN & bus.dmemWEN);
                end else if (bus.imemREN) begin
                    state_d = ARB_IACC;
                    last_d  = 1'b0;
                    addr_d  = bus.imemaddr;
                    wen_d   = 1'b0;
                end
            ARB_IACC:
                if (done) begin
                    state_d = ARB_IRESP;
                    iload_d = rdata;
                    err_d   = err_q | (bus.ramstate != ACCESS);
                end
            ARB_DACC:
                if (done) begin
                    state_d = ARB_DRESP;
                    dload_d = wen_q ? dload_q : rdata;
                    err_d   = err_q | (bus.ramstate != ACCESS);
                end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign bus.ramREN   = state_q == ARB_IACC || (d_acc && !wen_q);
    assign bus.ramWEN   = d_acc && wen_q;
    assign bus.ramaddr  = in_acc ? addr_q : '0;
    assign bus.ramstore = d_acc && wen_q ? store_q : '0;
    assign bus.ihit     = state_q == ARB_IRESP;
    assign bus.dhit     = state_q == ARB_DRESP;
    assign bus.imemload = iload_q;
    assign bus.dmemload = dload_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table-driven per-cycle vectors plus directed write, timeout,
// reset, RAM-error and REN/WEN conflict sequences.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    typedef struct {
        logic iren, dren;
        word_t iaddr, daddr;
        ramstate_t rs;
        word_t rload;
        logic ihit, dhit, rren;
        word_t raddr, iload, dload;
    } vec_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    vec_t v[14];

    ram_arbiter_if bus();
    ram_arbiter dut(.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    function automatic vec_t mk(input logic iren, dren, input word_t iaddr, daddr,
                                input ramstate_t rs, input word_t rload,
                                input logic ihit, dhit, rren, input word_t raddr, iload, dload);
        vec_t t;
        t.iren = iren; t.dren = dren; t.iaddr = iaddr; t.daddr = daddr;
        t.rs = rs; t.rload = rload; t.ihit = ihit; t.dhit = dhit; t.rren = rren;
        t.raddr = raddr; t.iload = iload; t.dload = dload;
        return t;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int acc;
        logic got;
        v[0]  = mk(1, 0, 32'h40, 32'h0,   FREE,   32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0);
        v[1]  = mk(1, 0, 32'h40, 32'h0,   ACCESS, 32'h8C220004, 0, 0, 1, 32'h40,  32'h0,        32'h0);
        v[2]  = mk(1, 0, 32'h40, 32'h0,   FREE,   32'h0,        1, 0, 0, 32'h0,   32'h8C220004, 32'h0);
        v[3]  = mk(0, 0, 32'h0,  32'h0,   FREE,   32'h0,        0, 0, 0, 32'h0,   32'h8C220004, 32'h0);
        v[4]  = mk(1, 1, 32'h80, 32'h200, FREE,   32'h0,        0, 0, 0, 32'h0,   32'h8C220004, 32'h0);
        v[5]  = mk(1, 1, 32'h80, 32'h200, ACCESS, 32'h11111111, 0, 0, 1, 32'h200, 32'h8C220004, 32'h0);
        v[6]  = mk(1, 1, 32'h80, 32'h200, FREE,   32'h0,        0, 1, 0, 32'h0,   32'h8C220004, 32'h11111111);
        v[7]  = mk(1, 1, 32'h80, 32'h204, FREE,   32'h0,        0, 0, 0, 32'h0,   32'h8C220004, 32'h11111111);
        v[8]  = mk(1, 1, 32'h80, 32'h204, ACCESS, 32'h22222222, 0, 0, 1, 32'h80,  32'h8C220004, 32'h11111111);
        v[9]  = mk(1, 1, 32'h80, 32'h204, FREE,   32'h0,        1, 0, 0, 32'h0,   32'h22222222, 32'h11111111);
        v[10] = mk(0, 1, 32'h0,  32'h204, FREE,   32'h0,        0, 0, 0, 32'h0,   32'h22222222, 32'h11111111);
        v[11] = mk(0, 0, 32'h0,  32'h0,   ACCESS, 32'h33333333, 0, 0, 1, 32'h204, 32'h22222222, 32'h11111111);
        v[12] = mk(0, 0, 32'h0,  32'h0,   FREE,   32'h0,        0, 1, 0, 32'h0,   32'h22222222, 32'h33333333);
        v[13] = mk(0, 0, 32'h0,  32'h0,   FREE,   32'h0,        0, 0, 0, 32'h0,   32'h22222222, 32'h33333333);

        bus.imemREN = 0; bus.imemaddr = 0; bus.dmemREN = 0; bus.dmemWEN = 0;
        bus.dmemaddr = 0; bus.dmemstore = 0; bus.ramload = 0; bus.ramstate = FREE;
        repeat (2) tick();
        chk("rst_ihit", bus.ihit, 0);
        chk("rst_dhit", bus.dhit, 0);
        chk("rst_ramREN", bus.ramREN, 0);
        chk("rst_ramWEN", bus.ramWEN, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_imemload", bus.imemload, 0);
        RST = 0;

        for (int i = 0; i < 14; i++) begin
            bus.imemREN = v[i].iren; bus.dmemREN = v[i].dren;
            bus.imemaddr = v[i].iaddr; bus.dmemaddr = v[i].daddr;
            bus.ramstate = v[i].rs; bus.ramload = v[i].rload;
            @(negedge CLK);
            chk($sformatf("v%0d_ihit", i), bus.ihit, v[i].ihit);
            chk($sformatf("v%0d_dhit", i), bus.dhit, v[i].dhit);
            chk($sformatf("v%0d_ramREN", i), bus.ramREN, v[i].rren);
            chk($sformatf("v%0d_ramWEN", i), bus.ramWEN, 0);
            chk($sformatf("v%0d_ramaddr", i), bus.ramaddr, v[i].raddr);
            chk($sformatf("v%0d_imemload", i), bus.imemload, v[i].iload);
            chk($sformatf("v%0d_dmemload", i), bus.dmemload, v[i].dload);
            chk($sformatf("v%0d_err", i), bus.err, 0);
            tick();
        end

        // write with 3 BUSY cycles; requester address changes must be ignored
        bus.dmemWEN = 1; bus.dmemaddr = 32'h100; bus.dmemstore = 32'hDEADBEEF; bus.ramstate = FREE;
        @(negedge CLK);
        chk("wr_idle_ramWEN", bus.ramWEN, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.ramstate = k < 3 ? BUSY : ACCESS;
            bus.dmemaddr = 32'h999; bus.dmemstore = 32'h0;
            @(negedge CLK);
            chk($sformatf("wr%0d_ramWEN", k), bus.ramWEN, 1);
            chk($sformatf("wr%0d_ramREN", k), bus.ramREN, 0);
            chk($sformatf("wr%0d_ramaddr", k), bus.ramaddr, 32'h100);
            chk($sformatf("wr%0d_ramstore", k), bus.ramstore, 32'hDEADBEEF);
            tick();
        end
        bus.ramstate = FREE;
        @(negedge CLK);
        chk("wr_dhit", bus.dhit, 1);
        chk("wr_dmemload", bus.dmemload, 32'h33333333);
        chk("wr_err", bus.err, 0);
        tick();
        bus.dmemWEN = 0;
        @(negedge CLK);
        chk("wr_after_dhit", bus.dhit, 0);
        chk("wr_after_ramWEN", bus.ramWEN, 0);
        tick();

        // RAM stuck BUSY: forced completion after TIMEOUT access cycles
        bus.dmemREN = 1; bus.dmemaddr = 32'h180; bus.ramstate = BUSY;
        tick();
        acc = 0; got = 0;
        for (int n = 0; n < 200; n++) begin
            @(negedge CLK);
            if (bus.dhit) begin
                got = 1;
                break;
            end
            if (bus.ramREN) acc++;
            tick();
        end
        chk("to_dhit_seen", got, 1);
        chk("to_acc_cycles", acc, 64);
        chk("to_dmemload", bus.dmemload, 32'hBAD1BAD1);
        chk("to_err", bus.err, 1);
        tick();
        bus.dmemREN = 0; bus.ramstate = FREE;
        repeat (3) tick();
        chk("to_err_sticky", bus.err, 1);
        chk("to_no_regrant", bus.ramREN, 0);

        // asynchronous reset in the middle of a data access
        bus.dmemREN = 1; bus.dmemaddr = 32'h300; bus.ramstate = BUSY;
        tick();
        @(negedge CLK);
        chk("rm_ramREN_before", bus.ramREN, 1);
        RST = 1;
        #1;
        chk("rm_ramREN", bus.ramREN, 0);
        chk("rm_ramaddr", bus.ramaddr, 0);
        chk("rm_dhit", bus.dhit, 0);
        chk("rm_dmemload", bus.dmemload, 0);
        chk("rm_imemload", bus.imemload, 0);
        chk("rm_err", bus.err, 0);
        bus.dmemREN = 0; bus.ramstate = FREE;
        #2 RST = 0;
        tick();
        @(negedge CLK);
        chk("rm_idle_ramREN", bus.ramREN, 0);
        chk("rm_idle_dhit", bus.dhit, 0);
        tick();

        // RAM ERROR on an instruction read
        bus.imemREN = 1; bus.imemaddr = 32'h44; bus.ramstate = FREE;
        tick();
        bus.ramstate = ERROR;
        @(negedge CLK);
        chk("re_ramREN", bus.ramREN, 1);
        chk("re_ramaddr", bus.ramaddr, 32'h44);
        tick();
        bus.ramstate = FREE;
        @(negedge CLK);
        chk("re_ihit", bus.ihit, 1);
        chk("re_dhit", bus.dhit, 0);
        chk("re_imemload", bus.imemload, 32'hBAD1BAD1);
        chk("re_err", bus.err, 1);
        tick();
        bus.imemREN = 0;
        RST = 1;
        #1;
        chk("re_rst_err", bus.err, 0);
        RST = 0;
        tick();

        // REN and WEN together: write performed, err raised
        bus.dmemREN = 1; bus.dmemWEN = 1; bus.dmemaddr = 32'h120; bus.dmemstore = 32'h55AA55AA;
        tick();
        bus.ramstate = ACCESS; bus.ramload = 32'h77777777;
        @(negedge CLK);
        chk("cf_ramWEN", bus.ramWEN, 1);
        chk("cf_ramREN", bus.ramREN, 0);
        chk("cf_ramstore", bus.ramstore, 32'h55AA55AA);
        chk("cf_err", bus.err, 1);
        tick();
        bus.ramstate = FREE;
        @(negedge CLK);
        chk("cf_dhit", bus.dhit, 1);
        chk("cf_dmemload", bus.dmemload, 0);
        tick();
        bus.dmemREN = 0; bus.dmemWEN = 0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
